oled_text_streamer: RTL and testbench
=====================================

# oled_text_streamer

Parametrised message streamer feeding the OLED controller's byte handshake (`send_data` / `send_data_valid` / `send_done`). It replaces the fixed, free-running string sender with a triggered engine that supports:

- a runtime-selected message length,
- optional continuous repeat,
- a programmable inter-character gap,
- clean abort,
- busy/done status.

It sits between application logic and the OLED controller.

## Interface

Parameters:
- `MSG_LEN`, 21 — number of characters held in `MSG` (≥1)
- `MSG`, "Shriya is a good girl" — packed ASCII, `8*MSG_LEN` bits; character 0 occupies the MSBs `[8*MSG_LEN-1 -: 8]`
- `GAP_CYCLES`, 0 — idle clocks inserted after each accepted byte (0 = none)
- `LW`, `$clog2(MSG_LEN+1)` — width of length/index fields

Ports:
- `clock` in 1 — system clock (100 MHz)
- `reset_n` in 1 — asynchronous, active-low reset
- `start` in 1 — single-cycle request to begin a message; sampled only in IDLE
- `len` in LW — characters to send; latched on accepted `start`; values > `MSG_LEN` are clamped to `MSG_LEN`
- `repeat_en` in 1 — latched on accepted `start`; 1 = restart at character 0 after the last character, until aborted
- `abort` in 1 — single-cycle stop request
- `send_done` in 1 — controller byte-complete, level signal
- `send_data` out 8 — character to the controller
- `send_data_valid` out 1 — byte request to the controller
- `busy` out 1 — high from accepted `start` until return to IDLE
- `done` out 1 — one-cycle pulse on normal completion
- `char_index` out LW — index of the current/next character

## Operation

**States:** IDLE, WAIT_RDY, SEND, GAP, FINISH.

**IDLE**
- Entered on `start`=1: latch `min(len, MSG_LEN)` and `repeat_en`, set `char_index`=0, `busy`=1.
- Latched length 0 → FINISH directly, no byte is sent.
- Otherwise → WAIT_RDY.

**WAIT_RDY**
- Waits for `send_done`=0, which guards against a stale done from the previous byte.
- Then loads `send_data` = `MSG[8*(MSG_LEN-char_index)-1 -: 8]`, sets `send_data_valid`=1 → SEND.

**SEND**
- `send_data_valid` and `send_data` are held stable until `send_done`=1.
- On `send_done`=1: `send_data_valid`=0.
  - If not the last character: `char_index`+1, → GAP (or → WAIT_RDY when `GAP_CYCLES`=0).
  - If last character and repeat latched: `char_index`=0, → GAP/WAIT_RDY.
  - If last character and not repeating: → FINISH.

**GAP**
- Counts `GAP_CYCLES` clocks, then → WAIT_RDY.

**FINISH**
- `done`=1 for one cycle, `busy`=0 → IDLE.

**Abort**
- `abort` sets a sticky flag while `busy`.
- In WAIT_RDY or GAP, the flag forces → IDLE next cycle with `busy`=0, no `done` pulse, `send_data_valid` stays 0.
- In SEND, the current byte completes (valid is never dropped before `send_done`), then → IDLE with no `done` pulse.
- The flag clears on entry to IDLE.
- `abort` in IDLE is ignored.

**Other rules**
- `start` while `busy` is ignored.
- Simultaneous `start` and `abort` in IDLE: `start` wins and `abort` is ignored.
- `char_index` wrap: `char_index` never exceeds latched length −1.

**Reset** (async, any state): state=IDLE, `send_data`=8'h00, `send_data_valid`=0, `busy`=0, `done`=0, `char_index`=0, gap counter=0, abort flag=0. Reset mid-byte drops valid immediately.

## Timing

All outputs are registered.

- `start` at edge N → `busy`=1 after N; `send_data_valid`=1 after N+1 at the earliest (WAIT_RDY sees `send_done`=0).
- `send_done` high at edge M → `send_data_valid`=0 after M; the next valid rises after M+1+`GAP_CYCLES` at the earliest, and only once `send_done` has returned to 0.
- Last byte accepted at edge M (no repeat) → `done`=1 during cycle M+1..M+2 (FINISH), `busy` falls at M+2.
- Length 0: `start` at N → `done` pulse after N+1, `busy` high for 2 cycles, `send_data_valid` never asserted.
- Max throughput: one byte per controller transaction + 2 + `GAP_CYCLES` clocks.

## Test plan

- **Basic 5-char:** `MSG`="HELLO", `MSG_LEN`=5, `GAP_CYCLES`=0; controller model asserts `send_done` 3 cycles after valid; `start`, `len`=5 → bytes 0x48,0x45,0x4C,0x4C,0x4F in order, one `done` pulse, `busy` low afterwards, valid never drops before `send_done`.
- **Clamp and zero length:** `len`=7 on `MSG_LEN`=5 → exactly 5 bytes; `len`=0 → `done` 1 cycle after N+1, no valid.
- **Repeat + abort:** `repeat_en`=1, `len`=2 → stream 0x48,0x45,0x48,0x45…; `abort` pulse while in SEND → current byte finishes, then IDLE, no `done`, `busy`=0.
- **Gap and stale done:** `GAP_CYCLES`=4, controller holds `send_done` high 2 extra cycles → ≥4 clocks between valid fall and rise, and next valid waits for `send_done`=0.
- **Ignored start:** `start` pulses while `busy` → no restart, `char_index` sequence 0..4 undisturbed.
- **Async reset mid-byte:** `reset_n`=0 asynchronously while valid high → all outputs to reset values without a clock edge; after release, fresh `start` sends from 0x48.

Source files
------------

// File: rtl/oled_text_streamer_if.sv
// Byte handshake between the message streamer and the OLED controller.
// The streamer presents a character with send_data_valid and holds it until
// the controller answers with the level signal send_done.
interface oled_text_streamer_if;
    logic [7:0] send_data;
    logic       send_data_valid;
    logic       send_done;

    modport master (
        output send_data,
        output send_data_valid,
        input  send_done
    );

    modport slave (
        input  send_data,
        input  send_data_valid,
        output send_done
    );
endinterface

// File: rtl/oled_text_streamer.sv
// Triggered message streamer for the OLED controller byte handshake.
// Sends the first min(len, MSG_LEN) characters of MSG, optionally repeating,
// with a programmable idle gap after each accepted byte and a clean abort.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for start; busy drops here
// WAIT_RDY | waiting for send_done low (stale done guard), then present byte
// SEND     | byte presented, holding data/valid until send_done
// GAP      | down-counting idle clocks after an accepted byte
// FINISH   | one cycle that raises the done pulse before returning to IDLE
module oled_text_streamer #(
    parameter int                   MSG_LEN    = 21,
    parameter logic [8*MSG_LEN-1:0] MSG        = "Shriya is a good girl",
    parameter int                   GAP_CYCLES = 0,
    parameter int                   LW         = $clog2(MSG_LEN + 1)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [LW-1:0]               len,
    input  logic                        repeat_en,
    input  logic                        abort,
    oled_text_streamer_if.master        oled,
    output logic                        busy,
    output logic                        done,
    output logic [LW-1:0]               char_index
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        SEND     = 3'd2,
        GAP      = 3'd3,
        FINISH   = 3'd4
    } state_t;

    // Gap counter is sized for GAP_CYCLES-1; a zero gap skips the GAP state.
    localparam int            GW         = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
    localparam state_t        AFTER_BYTE = (GAP_CYCLES > 0) ? GAP : WAIT_RDY;
    localparam logic [LW-1:0] LEN_MAX    = LW'(MSG_LEN);

    state_t        state_q, state_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [LW-1:0] len_q, len_d;
    logic          rep_q, rep_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          abort_q, abort_d;

    logic [LW-1:0]          len_clamped;
    logic [8*MSG_LEN-1:0]   msg_shift;
    logic [7:0]             char_at_idx;
    logic                   last_char;
    logic                   abort_hit;

    // Character idx sits at the MSBs once the message is shifted left by 8*idx.
    assign msg_shift   = MSG << {idx_q, 3'b000};
    assign char_at_idx = msg_shift[8*MSG_LEN-1 -: 8];

    assign len_clamped = (len > LEN_MAX) ? LEN_MAX : len;
    assign last_char   = ((idx_q + LW'(1)) == len_q);

    // A pulse arriving this cycle acts immediately, not one cycle late.
    assign abort_hit   = abort_q | abort;

    // Next-state and next-output decode; every register defaults to holding.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        idx_d   = idx_q;
        len_d   = len_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        abort_d = abort_q;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                // busy_q is still high for the cycle right after FINISH.
                if (start && !busy_q) begin
                    len_d   = len_clamped;
                    rep_d   = repeat_en;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = (len_clamped == '0) ? FINISH : WAIT_RDY;
                end
            end

            WAIT_RDY: begin
                if (abort_hit) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (!oled.send_done) begin
                    data_d  = char_at_idx;
                    valid_d = 1'b1;
                    state_d = SEND;
                end
            end

            SEND: begin
                if (oled.send_done) begin
                    valid_d = 1'b0;
                    if (abort_hit) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else if (!last_char) begin
                        idx_d   = idx_q + LW'(1);
                        gap_d   = GAP_LOAD;
                        state_d = AFTER_BYTE;
                    end else if (rep_q) begin
                        idx_d   = '0;
                        gap_d   = GAP_LOAD;
                        state_d = AFTER_BYTE;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end

            GAP: begin
                if (abort_hit) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (gap_q == '0) begin
                    state_d = WAIT_RDY;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end

            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        // Sticky abort: cleared whenever the engine heads back to IDLE.
        if (state_d == IDLE) begin
            abort_d = 1'b0;
        end else if (abort && busy_q) begin
            abort_d = 1'b1;
        end
    end

    // State and registered outputs; reset drops valid without waiting for a clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
            len_q   <= '0;
            rep_q   <= 1'b0;
            gap_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            abort_q <= abort_d;
        end
    end

    assign oled.send_data       = data_q;
    assign oled.send_data_valid = valid_q;
    assign busy                 = busy_q;
    assign done                 = done_q;
    assign char_index           = idx_q;

endmodule

// File: tb/tb_oled_text_streamer.sv
// Bench for oled_text_streamer: two instances of a "HELLO" streamer, one with
// no gap and one with a 4-clock gap, each driven by a simple controller model.
module tb_oled_text_streamer;

    localparam int MLEN = 5;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    logic       start     [2];
    logic [2:0] len       [2];
    logic       repeat_en [2];
    logic       abort     [2];
    logic       busy_o    [2];
    logic       done_o    [2];
    logic [2:0] idx_o     [2];
    logic [7:0] sdata     [2];
    logic       svalid    [2];
    logic       sdone     [2];

    int cdelay [2];
    int chold  [2];
    int ccnt   [2];
    int hcnt   [2];

    oled_text_streamer_if bus0 ();
    oled_text_streamer_if bus1 ();

    assign sdata[0]       = bus0.send_data;
    assign svalid[0]      = bus0.send_data_valid;
    assign bus0.send_done = sdone[0];
    assign sdata[1]       = bus1.send_data;
    assign svalid[1]      = bus1.send_data_valid;
    assign bus1.send_done = sdone[1];

    oled_text_streamer #(.MSG_LEN(MLEN), .MSG("HELLO"), .GAP_CYCLES(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .start(start[0]), .len(len[0]),
        .repeat_en(repeat_en[0]), .abort(abort[0]), .oled(bus0.master),
        .busy(busy_o[0]), .done(done_o[0]), .char_index(idx_o[0]));

    oled_text_streamer #(.MSG_LEN(MLEN), .MSG("HELLO"), .GAP_CYCLES(4)) dut1 (
        .clock(clock), .reset_n(reset_n), .start(start[1]), .len(len[1]),
        .repeat_en(repeat_en[1]), .abort(abort[1]), .oled(bus1.master),
        .busy(busy_o[1]), .done(done_o[1]), .char_index(idx_o[1]));

    int vectors     = 0;
    int miscompares = 0;

    // Written by the controller model / monitor, only read by the stimulus.
    logic [7:0] rxq   [$];
    int         idxq  [$];
    int         idleq [$];
    int         viol      = 0;
    int         done_seen = 0;
    int         rises     = 0;

    string msg_s = "HELLO";

    // Controller model: raises send_done cdelay clocks after valid, keeps it
    // high for chold extra clocks after valid drops.
    initial begin
        for (int k = 0; k < 2; k++) begin
            sdone[k] = 1'b0;
            ccnt[k]  = 0;
            hcnt[k]  = 0;
        end
        forever begin
            @(posedge clock);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (!reset_n) begin
                    sdone[k] = 1'b0;
                    ccnt[k]  = 0;
                end else if (sdone[k]) begin
                    if (!svalid[k]) begin
                        if (hcnt[k] == 0) sdone[k] = 1'b0;
                        else hcnt[k] = hcnt[k] - 1;
                    end
                end else if (svalid[k]) begin
                    ccnt[k] = ccnt[k] + 1;
                    if (ccnt[k] >= cdelay[k]) begin
                        sdone[k] = 1'b1;
                        rxq.push_back(sdata[k]);
                        ccnt[k] = 0;
                        hcnt[k] = chold[k];
                    end
                end
            end
        end
    end

    // Protocol monitor: valid/data stability, stale-done guard, idle gaps.
    initial begin
        logic pv [2];
        logic pd [2];
        logic [7:0] pdat [2];
        int idle [2];
        logic con [2];
        for (int k = 0; k < 2; k++) begin
            pv[k] = 0; pd[k] = 0; pdat[k] = 0; idle[k] = 0; con[k] = 0;
        end
        forever begin
            @(negedge clock);
            for (int k = 0; k < 2; k++) begin
                if (!reset_n) begin
                    pv[k] = 0; pd[k] = 0; con[k] = 0;
                end else begin
                    if (done_o[k]) done_seen++;
                    if (pv[k] && !svalid[k] && !pd[k]) viol++;
                    if (pv[k] && svalid[k] && sdata[k] !== pdat[k]) viol++;
                    if (!pv[k] && svalid[k]) begin
                        if (pd[k]) viol++;
                        rises++;
                        idxq.push_back(int'(idx_o[k]));
                        if (con[k]) idleq.push_back(idle[k]);
                        con[k] = 0;
                    end
                    if (pv[k] && !svalid[k]) begin
                        con[k]  = 1;
                        idle[k] = 0;
                    end
                    if (con[k] && !svalid[k]) idle[k]++;
                    if (!busy_o[k]) con[k] = 0;
                    pv[k]   = svalid[k];
                    pd[k]   = sdone[k];
                    pdat[k] = sdata[k];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    function automatic int gap_of(input int k);
        return (k == 1) ? 4 : 0;
    endfunction

    task automatic chk_reset_outputs(input int k, input string tag);
        chk({tag, "_data"},  sdata[k],  0);
        chk({tag, "_valid"}, svalid[k], 0);
        chk({tag, "_busy"},  busy_o[k], 0);
        chk({tag, "_done"},  done_o[k], 0);
        chk({tag, "_index"}, idx_o[k],  0);
    endtask

    // Run one non-repeating message and compare against the reference:
    // bytes are MSG[0..n-1] with n = min(len, MLEN), one done pulse one
    // cycle before busy falls, gaps of at least GAP+1 idle clocks.
    task automatic run_msg(input int k, input int lenv, input int delay,
                           input int hold, input bit poke, input string tag);
        int n, rx_b, ix_b, il_b, vi_b, dn_b, rs_b;
        int cyc, done_cyc, first_rise;
        n    = (lenv > MLEN) ? MLEN : lenv;
        cdelay[k] = delay;
        chold[k]  = hold;
        rx_b = rxq.size(); ix_b = idxq.size(); il_b = idleq.size();
        vi_b = viol; dn_b = done_seen; rs_b = rises;

        start[k] = 1'b1; len[k] = 3'(lenv); repeat_en[k] = 1'b0;
        tick();
        start[k] = 1'b0; len[k] = 3'($urandom_range(0, 7)); repeat_en[k] = 1'($urandom);
        chk({tag, "_busy_after_start"}, busy_o[k], 1);
        cyc = 0; done_cyc = -1; first_rise = -1;
        while (busy_o[k] === 1'b1 && cyc < 3000) begin
            start[k] = (poke && (cyc % 7 == 3)) ? 1'b1 : 1'b0;
            tick();
            cyc++;
            if (done_o[k] === 1'b1 && done_cyc < 0) done_cyc = cyc;
            if (svalid[k] === 1'b1 && first_rise < 0) first_rise = cyc;
        end
        start[k] = 1'b0; repeat_en[k] = 1'b0;
        chk({tag, "_busy_low"}, busy_o[k], 0);
        tick();

        chk({tag, "_nbytes"}, rxq.size() - rx_b, n);
        for (int i = 0; i < n && (rx_b + i) < rxq.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), rxq[rx_b + i], msg_s[i]);
        end
        for (int i = 0; i < n && (ix_b + i) < idxq.size(); i++) begin
            chk($sformatf("%s_index%0d", tag, i), idxq[ix_b + i], i);
        end
        chk({tag, "_done_count"}, done_seen - dn_b, 1);
        chk({tag, "_protocol"}, viol - vi_b, 0);
        if (n == 0) begin
            chk({tag, "_zero_done_cycle"}, done_cyc, 1);
            chk({tag, "_zero_busy_cycles"}, cyc, 2);
            chk({tag, "_zero_no_valid"}, rises - rs_b, 0);
        end else begin
            chk({tag, "_done_before_busy_fall"}, done_cyc, cyc - 1);
            if (hold == 0) chk({tag, "_first_valid"}, first_rise, 1);
            for (int i = il_b; i < idleq.size(); i++) begin
                chk($sformatf("%s_gap%0d", tag, i - il_b), idleq[i] >= gap_of(k) + 1, 1);
            end
        end
    endtask

    initial begin
        int c, rx_b, dn_b, vi_b, rs_b, w;
        for (int k = 0; k < 2; k++) begin
            start[k] = 0; len[k] = 0; repeat_en[k] = 0; abort[k] = 0;
            cdelay[k] = 3; chold[k] = 0;
        end

        repeat (3) tick();
        chk_reset_outputs(0, "reset0");
        chk_reset_outputs(1, "reset1");
        reset_n = 1'b1;
        tick();
        chk_reset_outputs(0, "post_reset0");

        run_msg(0, 5, 3, 0, 0, "basic");
        run_msg(0, 5, 3, 1, 1, "ignored_start");
        run_msg(0, 7, 2, 0, 0, "clamp");
        run_msg(0, 0, 3, 0, 0, "zero_len0");
        run_msg(1, 0, 3, 0, 0, "zero_len1");
        run_msg(1, 5, 3, 2, 0, "gap_stale");
        run_msg(0, 5, 1, 2, 0, "stale_nogap");

        // Repeat with abort while a byte is in flight.
        cdelay[0] = 2; chold[0] = 1;
        rx_b = rxq.size(); dn_b = done_seen; vi_b = viol; rs_b = rises;
        start[0] = 1; len[0] = 2; repeat_en[0] = 1;
        tick();
        start[0] = 0; repeat_en[0] = 0;
        w = 0;
        while (!((rises - rs_b) >= 5 && svalid[0] === 1'b1 && sdone[0] === 1'b0) && w < 500) begin
            tick(); w++;
        end
        chk("rep_reach_send", w < 500, 1);
        c = rxq.size() - rx_b;
        abort[0] = 1;
        tick();
        abort[0] = 0;
        w = 0;
        while (busy_o[0] === 1'b1 && w < 200) begin
            tick(); w++;
        end
        tick();
        chk("rep_abort_busy", busy_o[0], 0);
        chk("rep_abort_valid", svalid[0], 0);
        chk("rep_abort_nbytes", rxq.size() - rx_b, c + 1);
        chk("rep_abort_rises", rises - rs_b, c + 1);
        for (int i = 0; i < c + 1 && (rx_b + i) < rxq.size(); i++) begin
            chk($sformatf("rep_byte%0d", i), rxq[rx_b + i], msg_s[i % 2]);
        end
        chk("rep_abort_no_done", done_seen - dn_b, 0);
        chk("rep_abort_protocol", viol - vi_b, 0);

        // Abort during the gap: no further byte, quick return to IDLE.
        cdelay[1] = 2; chold[1] = 0;
        rx_b = rxq.size(); dn_b = done_seen; rs_b = rises;
        start[1] = 1; len[1] = 5;
        tick();
        start[1] = 0;
        w = 0;
        while (!((rises - rs_b) >= 1 && svalid[1] === 1'b0) && w < 200) begin
            tick(); w++;
        end
        chk("gap_abort_reach", w < 200, 1);
        abort[1] = 1;
        tick();
        abort[1] = 0;
        chk("gap_abort_busy", busy_o[1], 0);
        repeat (8) tick();
        chk("gap_abort_nbytes", rxq.size() - rx_b, 1);
        chk("gap_abort_rises", rises - rs_b, 1);
        chk("gap_abort_no_done", done_seen - dn_b, 0);

        // Asynchronous reset in the middle of a byte.
        cdelay[0] = 4; chold[0] = 0;
        start[0] = 1; len[0] = 5;
        tick();
        start[0] = 0;
        w = 0;
        while (svalid[0] !== 1'b1 && w < 50) begin
            tick(); w++;
        end
        chk("areset_valid_seen", svalid[0], 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs(0, "areset");
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        run_msg(0, 3, 3, 0, 0, "after_reset");

        // Randomized messages against the reference rules.
        for (int t = 0; t < 16; t++) begin
            run_msg(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                    int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
                    1'($urandom), $sformatf("rand%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
